// File: rtl/mode_select.sv
// Two-button mode selector: synchronise, debounce and auto-repeat next/prev buttons,
// then step a registered mode index with wrap/saturate, enable gate and direct load.
module mode_select #(
    parameter int NUM_MODES       = 4,
    parameter int MODE_W          = $clog2(NUM_MODES),
    parameter int RESET_MODE      = 0,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 25000000,
    parameter int WRAP            = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              load,
    input  logic [MODE_W-1:0] load_value,
    output logic [MODE_W-1:0] mode_out,
    output logic              mode_changed
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] RD_V      = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] RST_MODE  = MODE_W'(RESET_MODE);
    localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);
    localparam logic [MODE_W:0]   NM_EXT    = (MODE_W + 1)'(NUM_MODES);
    localparam bit                REPEAT_ON = (REPEAT_DELAY > 0);

    // Index 0 is the next button, index 1 the prev button.
    logic [1:0]        raw_s;
    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    logic [1:0]        deb_r;
    logic [1:0]        deb_d_r;
    logic [1:0]        armed_r;
    logic [1:0]        valid_r;
    logic [DB_W-1:0]   db_cnt_r   [2];
    logic [HOLD_W-1:0] hold_cnt_r [2];
    logic [1:0]        event_s;
    logic              both_held_s;
    logic [MODE_W-1:0] mode_r;
    logic [MODE_W-1:0] mode_nx_s;
    logic              changed_r;

    assign raw_s        = {btn_prev, btn_next};
    assign both_held_s  = deb_r[0] & deb_r[1];
    assign mode_out     = mode_r;
    assign mode_changed = changed_r;

    // Synchroniser, debounce, arming and hold counters for both buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            armed_r <= 2'b00;
            valid_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i]   <= '0;
                hold_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            valid_r <= {valid_r[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        deb_r[i]    <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
                // A button held through reset must be seen released before it may step.
                if (valid_r[1] && !deb_r[i] && !sync2_r[i]) begin
                    armed_r[i] <= 1'b1;
                end
                if (!deb_r[i] || !ena || both_held_s) begin
                    hold_cnt_r[i] <= '0;
                end else if (hold_cnt_r[i] == HOLD_TOP) begin
                    hold_cnt_r[i] <= RD_V;
                end else begin
                    hold_cnt_r[i] <= hold_cnt_r[i] + HOLD_ONE;
                end
            end
        end
    end

    // Press (debounced rising edge) or auto-repeat event per button.
    always_comb begin
        event_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (armed_r[i] && deb_r[i] && !deb_d_r[i]) begin
                event_s[i] = 1'b1;
            end else if (REPEAT_ON && armed_r[i] && deb_r[i] && hold_cnt_r[i] == RD_V) begin
                event_s[i] = 1'b1;
            end else begin
                event_s[i] = 1'b0;
            end
        end
    end

    // Next-mode selection in priority order: load, enable, conflict, next, prev.
    always_comb begin
        mode_nx_s = mode_r;
        if (load) begin
            if ({1'b0, load_value} >= NM_EXT) begin
                mode_nx_s = LAST_MODE;
            end else begin
                mode_nx_s = load_value;
            end
        end else if (!ena) begin
            mode_nx_s = mode_r;
        end else if ((event_s[0] && event_s[1]) || both_held_s) begin
            mode_nx_s = mode_r;
        end else if (event_s[0]) begin
            if (mode_r == LAST_MODE) begin
                mode_nx_s = (WRAP != 0) ? '0 : mode_r;
            end else begin
                mode_nx_s = mode_r + MODE_ONE;
            end
        end else if (event_s[1]) begin
            if (mode_r == '0) begin
                mode_nx_s = (WRAP != 0) ? LAST_MODE : mode_r;
            end else begin
                mode_nx_s = mode_r - MODE_ONE;
            end
        end else begin
            mode_nx_s = mode_r;
        end
    end

    // Mode register and its change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= RST_MODE;
            changed_r <= 1'b0;
        end else begin
            mode_r    <= mode_nx_s;
            changed_r <= (mode_nx_s != mode_r);
        end
    end

endmodule

// File: tb/tb_mode_select.sv
// Scoreboard bench for mode_select: three instances (4-mode wrap, 5-mode saturate,
// 5-mode wrap with auto-repeat) exercised one at a time.
module tb_mode_select;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic na = 1'b0, pa = 1'b0, la = 1'b0;
    logic nb = 1'b0, pb = 1'b0, lb = 1'b0;
    logic nc = 1'b0, pc = 1'b0, lc = 1'b0;
    logic [1:0] lva = 2'd0, ma;
    logic [2:0] lvb = 3'd0, lvc = 3'd0, mb, mc;
    logic ca, cb, cc;

    typedef struct { int inst; int mode; } exp_t;
    exp_t exp_q[$];
    int   cyc_c_q[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   exp_a = 0, exp_b = 0, exp_c = 0;

    always #5 clk = ~clk;

    mode_select #(.NUM_MODES(4), .RESET_MODE(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
                  .REPEAT_PERIOD(5), .WRAP(1)) u_a (
        .clk(clk), .rst(rst), .ena(ena), .btn_next(na), .btn_prev(pa), .load(la),
        .load_value(lva), .mode_out(ma), .mode_changed(ca));

    mode_select #(.NUM_MODES(5), .RESET_MODE(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
                  .REPEAT_PERIOD(5), .WRAP(0)) u_b (
        .clk(clk), .rst(rst), .ena(ena), .btn_next(nb), .btn_prev(pb), .load(lb),
        .load_value(lvb), .mode_out(mb), .mode_changed(cb));

    mode_select #(.NUM_MODES(5), .RESET_MODE(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
                  .REPEAT_PERIOD(5), .WRAP(1)) u_c (
        .clk(clk), .rst(rst), .ena(ena), .btn_next(nc), .btn_prev(pc), .load(lc),
        .load_value(lvc), .mode_out(mc), .mode_changed(cc));

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic push(input int inst, input int mode);
        exp_t e;
        e.inst = inst;
        e.mode = mode;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int inst, input int mode);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse_inst", inst, -1);
        end else begin
            e = exp_q.pop_front();
            check("sb_inst", inst, e.inst);
            check("sb_mode", mode, e.mode);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int inst, input bit prev, input logic v);
        case ({inst[1:0], prev})
            3'b000:  na = v;
            3'b001:  pa = v;
            3'b010:  nb = v;
            3'b011:  pb = v;
            3'b100:  nc = v;
            default: pc = v;
        endcase
    endtask

    // Short press: held 6 cycles, well under the repeat delay.
    task automatic tap(input int inst, input bit prev);
        set_btn(inst, prev, 1'b1);
        tick(6);
        set_btn(inst, prev, 1'b0);
        tick(12);
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Pop the scoreboard whenever any instance reports a change.
    always @(negedge clk) begin
        if (!rst) begin
            if (ca) pop_check(0, int'(ma));
            if (cb) pop_check(1, int'(mb));
            if (cc) begin
                pop_check(2, int'(mc));
                cyc_c_q.push_back(cycle);
            end
        end
    end

    always @(posedge clk) begin
        if (cycle > 20000) begin
            $display("FAIL watchdog: got cycle %0d expected below 20000", cycle);
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        int pat [10] = '{1, 2, 3, 1, 2, 3, 2, 1, 3, 2};
        int gaps [4] = '{10, 5, 5, 5};

        tick(3);
        check("rst_mode_a", int'(ma), 0);
        check("rst_chg_a", int'(ca), 0);
        check("rst_mode_b", int'(mb), 0);
        check("rst_mode_c", int'(mc), 0);
        rst = 1'b0;
        tick(4);

        // Basic cycle with exact latency: change on the 7th edge after the press.
        for (int i = 0; i < 4; i++) begin
            exp_a = (exp_a + 1) % 4;
            push(0, exp_a);
            na = 1'b1;
            tick(6);
            check("lat_early", int'(ma), (exp_a + 3) % 4);
            tick(1);
            check("lat_step", int'(ma), exp_a);
            tick(3);
            na = 1'b0;
            tick(10);
        end
        check("cycle_end", int'(ma), 0);

        // Bounce of 1-3 cycle pulses, then a stable press: one step.
        for (int i = 0; i < 10; i++) begin
            na = ~na;
            tick(pat[i]);
        end
        check("bounce_none", int'(ma), 0);
        exp_a = 1;
        push(0, exp_a);
        na = 1'b1;
        tick(10);
        na = 1'b0;
        tick(12);
        check("bounce_one", int'(ma), 1);

        // Saturating 5-mode instance.
        for (int i = 0; i < 6; i++) begin
            if (exp_b < 4) begin
                exp_b++;
                push(1, exp_b);
            end
            tap(1, 1'b0);
        end
        check("sat_top", int'(mb), 4);
        for (int i = 0; i < 6; i++) begin
            if (exp_b > 0) begin
                exp_b--;
                push(1, exp_b);
            end
            tap(1, 1'b1);
        end
        check("sat_bottom", int'(mb), 0);

        // Wrapping 5-mode instance: prev from 0.
        exp_c = 4;
        push(2, exp_c);
        tap(2, 1'b1);
        check("wrap_prev", int'(mc), 4);

        // Auto-repeat: held cycles 0,10,15,20,25 step.
        cyc_c_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_c = (exp_c + 1) % 5;
            push(2, exp_c);
        end
        nc = 1'b1;
        tick(28);
        nc = 1'b0;
        tick(20);
        check("rep_count", cyc_c_q.size(), 5);
        for (int i = 1; i < 5 && i < cyc_c_q.size(); i++)
            check("rep_gap", cyc_c_q[i] - cyc_c_q[i-1], gaps[i-1]);
        check("rep_final", int'(mc), 4);

        // Load wins over a coincident next event.
        push(0, 3);
        la = 1'b1; lva = 2'd3;
        tick(1);
        la = 1'b0;
        check("load3", int'(ma), 3);
        na = 1'b1;
        tick(6);
        la = 1'b1; lva = 2'd2;
        push(0, 2);
        tick(1);
        la = 1'b0;
        check("load_vs_next", int'(ma), 2);
        tick(4);
        na = 1'b0;
        tick(12);
        check("load_vs_next_after", int'(ma), 2);
        la = 1'b1; lva = 2'd2;
        tick(1);
        la = 1'b0;
        tick(2);
        check("load_same", int'(ma), 2);

        // Load clamp on the 5-mode instance.
        push(1, 4);
        lb = 1'b1; lvb = 3'd7;
        tick(1);
        lb = 1'b0;
        check("load_clamp", int'(mb), 4);
        lb = 1'b1;
        tick(1);
        lb = 1'b0;
        tick(2);
        check("load_clamp_again", int'(mb), 4);

        // Enable low through the press, restored while still held.
        ena = 1'b0;
        na = 1'b1;
        tick(12);
        ena = 1'b1;
        tick(10);
        na = 1'b0;
        tick(12);
        check("ena_gate", int'(ma), 2);

        // Both buttons held together.
        nb = 1'b1; pb = 1'b1;
        tick(10);
        nb = 1'b0; pb = 1'b0;
        tick(12);
        check("both_held", int'(mb), 4);

        // Reset mid-press, held through reset release.
        na = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("midrst_mode", int'(ma), 0);
        check("midrst_chg", int'(ca), 0);
        tick(1);
        rst = 1'b0;
        tick(20);
        check("held_after_rst", int'(ma), 0);
        na = 1'b0;
        tick(12);
        check("released_after_rst", int'(ma), 0);
        push(0, 1);
        tap(0, 1'b0);
        check("repress_after_rst", int'(ma), 1);

        tick(5);
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
